// File: rtl/sound_pkg.sv
// Shared constants, types and helpers for the four-channel mixer and DAC stage.
// Channel n is stored at index n-1 of every per-channel vector.
package sound_pkg;

  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned CH_COUNT  = 4;
  localparam int unsigned PCM_W     = 16;
  localparam int unsigned SDM_ACC_W = 17;
  localparam int          BIAS      = 15;

  localparam int unsigned VOL_W          = 3;
  localparam int unsigned NR50_LEFT_LSB  = 4;
  localparam int unsigned NR50_RIGHT_LSB = 0;
  localparam int unsigned NR51_LEFT_LSB  = 4;
  localparam int unsigned NR51_RIGHT_LSB = 0;

  localparam int unsigned TERM_W = LEVEL_W + 2;
  localparam int unsigned SUM_W  = 7;
  localparam int unsigned PROD_W = 10;

  typedef logic signed [TERM_W-1:0] term_t;
  typedef logic signed [SUM_W-1:0]  sum_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef struct packed {
    logic [CH_COUNT-1:0][LEVEL_W-1:0] level;
    logic [CH_COUNT-1:0]              enable;
    logic [CH_COUNT-1:0]              pan_left;
    logic [CH_COUNT-1:0]              pan_right;
    logic [VOL_W-1:0]                 vol_left;
    logic [VOL_W-1:0]                 vol_right;
    logic                             sound_on;
  } snap_t;

  // 2*level - 15, centred on zero; a disabled channel contributes silence.
  function automatic term_t remove_bias(input logic [LEVEL_W-1:0] level, input logic enable);
    term_t twice;
    twice = term_t'({level, 1'b0});
    return enable ? (twice - term_t'(BIAS)) : '0;
  endfunction

  // sum * (vol + 1) built from shifted copies of the sum.
  function automatic prod_t scale_volume(input sum_t sum, input logic [VOL_W-1:0] vol);
    prod_t base;
    prod_t acc;
    base = prod_t'(sum);
    acc  = base;
    for (int b = 0; b < VOL_W; b++) begin
      if (vol[b]) acc = acc + (base <<< b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sound_sdm.sv
// First-order sigma-delta modulator for one audio side.
// Signed PCM is turned into offset binary and the accumulator carry is the output bit.
module sound_sdm
  import sound_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PCM_W-1:0] i_pcm,
  output logic                    o_bit
);

  logic [PCM_W-1:0]     w_offset;
  logic [SDM_ACC_W-1:0] r_acc;

  // Adding 32768 to a 16-bit two's complement value is just an MSB flip.
  assign w_offset = {~i_pcm[PCM_W-1], i_pcm[PCM_W-2:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc <= '0;
    end else begin
      r_acc <= {1'b0, r_acc[PCM_W-1:0]} + {1'b0, w_offset};
    end
  end

  assign o_bit = r_acc[SDM_ACC_W-1];

endmodule

// File: rtl/sound_mixer_dac.sv
// Mixes the four tone channels into signed 16-bit PCM at a fixed sample rate
// and drives one sigma-delta bitstream per side.
module sound_mixer_dac
  import sound_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 48,
  parameter int unsigned PCM_SHIFT  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LEVEL_W-1:0]         ch1_level,
  input  logic [LEVEL_W-1:0]         ch2_level,
  input  logic [LEVEL_W-1:0]         ch3_level,
  input  logic [LEVEL_W-1:0]         ch4_level,
  input  logic [CH_COUNT-1:0]        ch_enable,
  input  logic                       sound_on,
  input  logic [7:0]                 nr50,
  input  logic [7:0]                 nr51,
  output logic signed [PCM_W-1:0]    pcm_left,
  output logic signed [PCM_W-1:0]    pcm_right,
  output logic                       pcm_valid,
  output logic                       sdm_left,
  output logic                       sdm_right
);

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_strobe;

  snap_t w_snap;
  snap_t r_snap;
  logic  r_v1;

  term_t w_term [CH_COUNT];
  sum_t  w_sum_left;
  sum_t  w_sum_right;
  sum_t  r_sum_left;
  sum_t  r_sum_right;
  logic [VOL_W-1:0] r_vol_left;
  logic [VOL_W-1:0] r_vol_right;
  logic  r_on2;
  logic  r_v2;

  prod_t r_prod_left;
  prod_t r_prod_right;
  logic  r_v3;

  logic signed [PCM_W-1:0] w_ext_left;
  logic signed [PCM_W-1:0] w_ext_right;

  // VIN routing bits of NR50 have no effect in this mixer.
  logic w_unused_vin;
  assign w_unused_vin = ^{nr50[7], nr50[3]};

  // Sample cadence.
  assign w_strobe = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Snapshot every control input at the strobe so later writes cannot disturb the sample.
  always_comb begin
    w_snap           = '0;
    w_snap.level     = {ch4_level, ch3_level, ch2_level, ch1_level};
    w_snap.enable    = ch_enable;
    w_snap.pan_left  = nr51[NR51_LEFT_LSB +: CH_COUNT];
    w_snap.pan_right = nr51[NR51_RIGHT_LSB +: CH_COUNT];
    w_snap.vol_left  = nr50[NR50_LEFT_LSB +: VOL_W];
    w_snap.vol_right = nr50[NR50_RIGHT_LSB +: VOL_W];
    w_snap.sound_on  = sound_on;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_snap <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_v1 <= w_strobe;
      if (w_strobe) r_snap <= w_snap;
    end
  end

  // Bias removal and per-side panning sum.
  always_comb begin
    w_sum_left  = '0;
    w_sum_right = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      w_term[i] = remove_bias(r_snap.level[i], r_snap.enable[i]);
      if (r_snap.pan_left[i])  w_sum_left  = w_sum_left  + sum_t'(w_term[i]);
      if (r_snap.pan_right[i]) w_sum_right = w_sum_right + sum_t'(w_term[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum_left  <= '0;
      r_sum_right <= '0;
      r_vol_left  <= '0;
      r_vol_right <= '0;
      r_on2       <= 1'b0;
      r_v2        <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum_left  <= w_sum_left;
        r_sum_right <= w_sum_right;
        r_vol_left  <= r_snap.vol_left;
        r_vol_right <= r_snap.vol_right;
        r_on2       <= r_snap.sound_on;
      end
    end
  end

  // Master volume; the result is held between samples and drives the PCM outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prod_left  <= '0;
      r_prod_right <= '0;
      r_v3         <= 1'b0;
    end else begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_prod_left  <= r_on2 ? scale_volume(r_sum_left, r_vol_left)   : '0;
        r_prod_right <= r_on2 ? scale_volume(r_sum_right, r_vol_right) : '0;
      end
    end
  end

  assign w_ext_left  = PCM_W'(r_prod_left);
  assign w_ext_right = PCM_W'(r_prod_right);
  assign pcm_left    = w_ext_left  <<< PCM_SHIFT;
  assign pcm_right   = w_ext_right <<< PCM_SHIFT;
  assign pcm_valid   = r_v3;

  sound_sdm u_sdm_left (
    .clk   (clk),
    .rst   (rst),
    .i_pcm (pcm_left),
    .o_bit (sdm_left)
  );

  sound_sdm u_sdm_right (
    .clk   (clk),
    .rst   (rst),
    .i_pcm (pcm_right),
    .o_bit (sdm_right)
  );

endmodule
